sar_timing_gen: RTL and testbench

Parametrised conversion timing generator for the SAR ADC front end; the successor to the fixed two-output clock generator. From the single system clock it derives a programmable sample window and N_BITS bit-cycle strobes, using clock enables rather than gated clocks. It supports single-shot and continuous conversion, abort, and a start/busy/done handshake. It drives the sample-and-hold switch control and the SAR register/comparator logic.

---
 rtl/sar_timing_pkg.sv | 24 ++
 rtl/sar_prescaler.sv | 33 +++
 rtl/sar_timing_gen.sv | 170 +++++++++++++++++
 tb/tb_sar_timing_gen.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_timing_pkg.sv
// sar_timing_pkg: shared types and constants for the SAR conversion timing
// generator.
//   sar_state_e : conversion FSM states (IDLE/SAMPLE/CONVERT/DONE)
//   DEF_*       : default parameter values used by sar_timing_gen
//   bidx_w()    : width of the bit-index bus for a given resolution
package sar_timing_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } sar_state_e;

  localparam int DEF_DIV_W  = 8;
  localparam int DEF_N_BITS = 8;
  localparam int DEF_SMP_W  = 8;

  // Bits needed to hold N_BITS-1 .. 0; never narrower than one bit.
  function automatic int bidx_w(input int n_bits);
    return (n_bits < 2) ? 1 : $clog2(n_bits);
  endfunction

endpackage

// File: rtl/sar_prescaler.sv
// sar_prescaler: free-running tick prescaler.
// Counts 0..ratio and wraps; tick is high while the count equals ratio, so
// the tick period is ratio+1 clocks (every clock when ratio is 0).
//   clk_in : system clock
//   rst    : synchronous active-high reset (count to 0)
//   clr    : synchronous clear, holds the count at 0
//   ratio  : terminal count D
//   tick   : high in the last cycle of each period
//   cnt    : current count, exported for clock-shape decoding
module sar_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] ratio,
  output logic             tick,
  output logic [DIV_W-1:0] cnt
);

  assign tick = (cnt == ratio);

  always_ff @(posedge clk_in) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == ratio) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sar_timing_gen.sv
// sar_timing_gen: SAR ADC conversion timing generator.
// Derives a programmable sample window and N_BITS bit-decision strobes from
// clk_in using clock enables. Single-shot (start) or continuous (cont_en)
// conversion, abort, and a busy/done handshake. All outputs are registered
// and lag the internal state by one cycle.
//   clk_in         : system clock
//   rst            : synchronous active-high reset
//   start          : single-shot request, honoured in IDLE only
//   cont_en        : back-to-back conversions while high
//   abort          : back to IDLE on the next edge, no done pulse
//   div_ratio      : tick period minus one (D), latched at conversion start
//   sample_len     : sample window in ticks (S, 0 acts as 1), latched likewise
//   sample_en      : high for the whole sample window
//   sar_tick       : one-cycle strobe per bit decision
//   bit_idx        : bit under decision, N_BITS-1 down to 0
//   conv_busy      : high while sampling or converting
//   conv_done      : one-cycle pulse at the end of a conversion
//   clk_out_sample : sample_en delayed one cycle (SAR_CLK_OUT_EN only, else 0)
//   clk_out_sar    : bit clock, high for cnt <= D/2 in CONVERT
//                    (SAR_CLK_OUT_EN only, else 0)
// Build option: define SAR_CLK_OUT_EN to generate the two registered clocks.
module sar_timing_gen
  import sar_timing_pkg::*;
#(
  parameter int DIV_W  = DEF_DIV_W,
  parameter int N_BITS = DEF_N_BITS,
  parameter int SMP_W  = DEF_SMP_W
) (
  input  logic                      clk_in,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      cont_en,
  input  logic                      abort,
  input  logic [DIV_W-1:0]          div_ratio,
  input  logic [SMP_W-1:0]          sample_len,
  output logic                      sample_en,
  output logic                      sar_tick,
  output logic [bidx_w(N_BITS)-1:0] bit_idx,
  output logic                      conv_busy,
  output logic                      conv_done,
  output logic                      clk_out_sample,
  output logic                      clk_out_sar
);

  localparam int             BW      = bidx_w(N_BITS);
  localparam logic [BW-1:0]  TOP_BIT = BW'(N_BITS - 1);

  sar_state_e       state;
  logic [DIV_W-1:0] d_lat;
  logic [SMP_W-1:0] s_last;
  logic [SMP_W-1:0] smp_cnt;
  logic [BW-1:0]    bit_q;
  logic             tick;
  logic             clr;
  logic             launch;
  logic [DIV_W-1:0] cnt;

  // IDLE and DONE hold the prescaler at 0 so every conversion starts with a
  // fresh full-length tick period.
  assign clr    = (state == IDLE) || (state == DONE);
  assign launch = ((state == IDLE) && (start || cont_en)) ||
                  ((state == DONE) && cont_en);

  sar_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk_in (clk_in),
    .rst    (rst),
    .clr    (clr),
    .ratio  (d_lat),
    .tick   (tick),
    .cnt    (cnt)
  );

  // Conversion settings are pure data: captured at each launch, no reset.
  always_ff @(posedge clk_in) begin
    if (!rst && !abort && launch) begin
      d_lat  <= div_ratio;
      s_last <= (sample_len == '0) ? '0 : sample_len - 1'b1;
    end
  end

  // Stage boundary: internal FSM state -> registered outputs (one cycle lag).
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state     <= IDLE;
      smp_cnt   <= '0;
      bit_q     <= '0;
      sample_en <= 1'b0;
      sar_tick  <= 1'b0;
      bit_idx   <= '0;
      conv_busy <= 1'b0;
      conv_done <= 1'b0;
    end else if (abort) begin
      // Outputs drop together with the state so busy is low the cycle after.
      state     <= IDLE;
      bit_q     <= '0;
      sample_en <= 1'b0;
      sar_tick  <= 1'b0;
      bit_idx   <= '0;
      conv_busy <= 1'b0;
      conv_done <= 1'b0;
    end else begin
      sample_en <= (state == SAMPLE);
      sar_tick  <= (state == CONVERT) && tick;
      bit_idx   <= bit_q;
      conv_busy <= (state == SAMPLE) || (state == CONVERT);
      conv_done <= (state == DONE);
      case (state)
        IDLE: begin
          if (launch) begin
            state   <= SAMPLE;
            smp_cnt <= '0;
            bit_q   <= TOP_BIT;
          end
        end
        SAMPLE: begin
          if (tick) begin
            if (smp_cnt == s_last) begin
              state <= CONVERT;
            end else begin
              smp_cnt <= smp_cnt + 1'b1;
            end
          end
        end
        CONVERT: begin
          if (tick) begin
            if (bit_q == '0) begin
              state <= DONE;
            end else begin
              bit_q <= bit_q - 1'b1;
            end
          end
        end
        DONE: begin
          if (launch) begin
            state   <= SAMPLE;
            smp_cnt <= '0;
            bit_q   <= TOP_BIT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SAR_CLK_OUT_EN
  logic [DIV_W-1:0] half_d;
  assign half_d = d_lat >> 1;

  // Stage boundary: decoded clock shapes -> registered clock outputs.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      clk_out_sample <= 1'b0;
      clk_out_sar    <= 1'b0;
    end else begin
      clk_out_sample <= sample_en;
      clk_out_sar    <= !abort && (state == CONVERT) && (cnt <= half_d);
    end
  end
`else
  logic unused_cnt;
  assign unused_cnt     = ^cnt;
  assign clk_out_sample = 1'b0;
  assign clk_out_sar    = 1'b0;
`endif

endmodule

// File: tb/tb_sar_timing_gen.sv
module tb_sar_timing_gen;

  logic       clk_in;
  logic       rst;
  logic       start;
  logic       cont_en;
  logic       abort;
  logic [7:0] div_ratio;
  logic [7:0] sample_len;

  logic       smp8, tick8, busy8, done8, cs8, csar8;
  logic [2:0] bidx8;
  logic       smp4, tick4, busy4, done4, cs4, csar4;
  logic [1:0] bidx4;

  sar_timing_gen #(.DIV_W(8), .N_BITS(8), .SMP_W(8)) u_dut8 (
    .clk_in(clk_in), .rst(rst), .start(start), .cont_en(cont_en),
    .abort(abort), .div_ratio(div_ratio), .sample_len(sample_len),
    .sample_en(smp8), .sar_tick(tick8), .bit_idx(bidx8),
    .conv_busy(busy8), .conv_done(done8),
    .clk_out_sample(cs8), .clk_out_sar(csar8)
  );

  sar_timing_gen #(.DIV_W(8), .N_BITS(4), .SMP_W(8)) u_dut4 (
    .clk_in(clk_in), .rst(rst), .start(start), .cont_en(cont_en),
    .abort(abort), .div_ratio(div_ratio), .sample_len(sample_len),
    .sample_en(smp4), .sar_tick(tick4), .bit_idx(bidx4),
    .conv_busy(busy4), .conv_done(done4),
    .clk_out_sample(cs4), .clk_out_sar(csar4)
  );

  logic [5:0] obs8, obs4;
  assign obs8 = {cs8, csar8, smp8, tick8, busy8, done8};
  assign obs4 = {cs4, csar4, smp4, tick4, busy4, done4};

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int d;
    int s;
    bit n4;
    int smp_last;
    int first_tick;
    int done_cyc;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 'h%0h, expected 'h%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; cont_en = 1'b0; abort = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("reset_outs8", int'(obs8), 0);
    chk("reset_bidx8", int'(bidx8), 0);
    chk("reset_outs4", int'(obs4), 0);
    chk("reset_bidx4", int'(bidx4), 0);
  endtask

  task automatic launch(input int d, input int s);
    div_ratio  = 8'(d);
    sample_len = 8'(s);
    start = 1'b1;
    cyc = -1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cont_en = 1'b0; abort = 1'b0;
    div_ratio = 8'd0; sample_len = 8'd0;

    // d, s, N=4?, last sample_en cycle, first sar_tick cycle, conv_done cycle
    vecs[0] = '{d: 3, s: 2, n4: 1'b0, smp_last: 8, first_tick: 12, done_cyc: 41};
    vecs[1] = '{d: 0, s: 0, n4: 1'b1, smp_last: 1, first_tick: 2,  done_cyc: 6};
    vecs[2] = '{d: 0, s: 0, n4: 1'b0, smp_last: 1, first_tick: 2,  done_cyc: 10};
    vecs[3] = '{d: 1, s: 1, n4: 1'b0, smp_last: 2, first_tick: 4,  done_cyc: 19};
    vecs[4] = '{d: 2, s: 3, n4: 1'b1, smp_last: 9, first_tick: 12, done_cyc: 22};
    vecs[5] = '{d: 4, s: 1, n4: 1'b1, smp_last: 5, first_tick: 10, done_cyc: 26};

    // Table-driven single-shot conversions with busy-time start pulses and
    // mid-conversion setting changes that must not take effect.
    for (int vi = 0; vi < 6; vi++) begin
      vec_t v;
      int   nb;
      int   ticks;
      v  = vecs[vi];
      nb = v.n4 ? 4 : 8;
      ticks = 0;
      do_reset();
      launch(v.d, v.s);
      for (int c = 0; c <= v.done_cyc + 3; c++) begin
        logic e_smp, e_tick, e_busy, e_done, e_cs, e_csar;
        logic [5:0] ev;
        logic [5:0] got;
        int gbit;
        e_smp  = (c >= 1) && (c <= v.smp_last);
        e_busy = (c >= 1) && (c <= v.done_cyc - 1);
        e_done = (c == v.done_cyc);
        e_tick = (c >= v.first_tick) && (c <= v.done_cyc - 1) &&
                 (((c - v.first_tick) % (v.d + 1)) == 0);
`ifdef SAR_CLK_OUT_EN
        e_cs   = (c >= 2) && (c <= v.smp_last + 1);
        e_csar = (c >= v.smp_last + 1) && (c <= v.done_cyc - 1) &&
                 (((c - v.smp_last - 1) % (v.d + 1)) <= (v.d / 2));
`else
        e_cs   = 1'b0;
        e_csar = 1'b0;
`endif
        ev   = {e_cs, e_csar, e_smp, e_tick, e_busy, e_done};
        got  = v.n4 ? obs4 : obs8;
        gbit = v.n4 ? int'(bidx4) : int'(bidx8);
        chk($sformatf("vec%0d_outs", vi), int'(got), int'(ev));
        if (e_tick) begin
          chk($sformatf("vec%0d_bit_idx", vi), gbit, nb - 1 - (c - v.first_tick) / (v.d + 1));
        end
        if (got[2]) ticks++;
        if (c == 3) begin
          div_ratio  = 8'd7;
          sample_len = 8'd5;
        end
        start = (c == 2) || (c == v.done_cyc - 3);
        step();
      end
      start = 1'b0;
      chk($sformatf("vec%0d_tick_count", vi), ticks, nb);
      chk($sformatf("vec%0d_idle_bit_idx", vi), v.n4 ? int'(bidx4) : int'(bidx8), 0);
    end

    // Continuous mode, D=1 S=1: period 19; D changed mid third conversion
    // only stretches the fourth (1+9*4 = 37); cont_en dropped mid fourth.
    begin
      int dq[8];
      int nd;
      nd = 0;
      do_reset();
      div_ratio = 8'd1; sample_len = 8'd1; cont_en = 1'b1;
      cyc = -1;
      step();
      for (int c = 0; c < 140; c++) begin
        if (done8 && nd < 8) begin
          dq[nd] = c;
          nd++;
        end
        if (c == 100) chk("cont_idle_busy", int'(busy8), 0);
        if (c == 40) div_ratio = 8'd3;
        if (c == 60) cont_en = 1'b0;
        step();
      end
      chk("cont_done_count", nd, 4);
      chk("cont_done0", (nd > 0) ? dq[0] : -1, 19);
      chk("cont_done1", (nd > 1) ? dq[1] : -1, 38);
      chk("cont_done2", (nd > 2) ? dq[2] : -1, 57);
      chk("cont_done3", (nd > 3) ? dq[3] : -1, 94);
    end

    // Abort at the third sar_tick, then a clean conversion.
    begin
      int ticks;
      int tcyc;
      int dones;
      int dcyc;
      ticks = 0; tcyc = -1; dones = 0; dcyc = -1;
      do_reset();
      launch(3, 2);
      for (int i = 0; i < 100 && ticks < 3; i++) begin
        if (tick8) begin
          ticks++;
          tcyc = cyc;
        end
        if (ticks < 3) step();
      end
      chk("abort_third_tick_seen", ticks, 3);
      chk("abort_third_tick_cycle", tcyc, 20);
      chk("abort_third_tick_bit", int'(bidx8), 5);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_outs_cleared", int'(obs8[3:0]), 0);
      for (int i = 0; i < 50; i++) begin
        if (done8 || busy8) dones++;
        step();
      end
      chk("abort_no_done_or_busy", dones, 0);
      launch(3, 2);
      for (int c = 0; c < 50; c++) begin
        if (done8 && dcyc < 0) dcyc = c;
        step();
      end
      chk("after_abort_done_cycle", dcyc, 41);
    end

    // Reset in the middle of CONVERT, start pulses while busy.
    begin
      int busy_seen;
      busy_seen = 0;
      do_reset();
      launch(3, 2);
      for (int c = 0; c < 15; c++) begin
        start = (c == 10);
        step();
      end
      start = 1'b0;
      chk("rst_pre_busy", int'(busy8), 1);
      rst = 1'b1;
      step();
      chk("rst_mid_outs8", int'(obs8), 0);
      chk("rst_mid_bidx8", int'(bidx8), 0);
      chk("rst_mid_outs4", int'(obs4), 0);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (busy8 || busy4) busy_seen++;
        step();
      end
      chk("rst_stays_idle", busy_seen, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
